// File: rtl/acc_pkg.sv
// Shared types and helpers for the multi-lane accumulator.
// Optional feature macro: ACC_SAT_EN (saturating lane adds with sticky overflow flags).
package acc_pkg;

   // Two-state result handshake FSM
   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } acc_state_e;

   localparam int ACC_DEF_WIDTH     = 32;
   localparam int ACC_DEF_ACC_WIDTH = 40;
   localparam int ACC_DEF_LANES     = 4;
   localparam int ACC_DEF_CNT_WIDTH = 16;

   // Widest accumulator the saturation helper supports
   localparam int SAT_MAX_W = 128;
   typedef logic signed [SAT_MAX_W-1:0] wide_t;
   localparam logic signed [SAT_MAX_W:0] SAT_ONE = 1;

   // Signed add of two sign-extended w-bit values, clamped to the w-bit signed range.
   // ovf is set when the clamp was applied.
   function automatic wide_t sat_add(input wide_t a, input wide_t b, input int w,
                                     output logic ovf);
      logic signed [SAT_MAX_W:0] sum;
      logic signed [SAT_MAX_W:0] hi;
      logic signed [SAT_MAX_W:0] lo;
      wide_t                     res;
      sum = $signed({a[SAT_MAX_W-1], a}) + $signed({b[SAT_MAX_W-1], b});
      hi  = (SAT_ONE <<< (w - 1)) - SAT_ONE;
      lo  = -(SAT_ONE <<< (w - 1));
      ovf = 1'b0;
      res = sum[SAT_MAX_W-1:0];
      if (sum > hi) begin
         res = hi[SAT_MAX_W-1:0];
         ovf = 1'b1;
      end else if (sum < lo) begin
         res = lo[SAT_MAX_W-1:0];
         ovf = 1'b1;
      end
      return res;
   endfunction

endpackage

// File: rtl/acc_lane.sv
// Single-lane signed accumulator: sign-extends the input lane and adds it into a
// running sum. Under ACC_SAT_EN the add clamps and raises a sticky overflow flag;
// otherwise the sum wraps and the flag is tied low.
module acc_lane
   import acc_pkg::*;
#(
   parameter int WIDTH     = ACC_DEF_WIDTH,
   parameter int ACC_WIDTH = ACC_DEF_ACC_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr_i,
   input  logic                 en_i,
   input  logic [WIDTH-1:0]     data_i,
   output logic [ACC_WIDTH-1:0] acc_o,
   output logic                 ovf_o
);

   logic signed [WIDTH-1:0]     data_s;
   logic signed [ACC_WIDTH-1:0] ext;
   logic signed [ACC_WIDTH-1:0] acc_q;
   logic signed [ACC_WIDTH-1:0] acc_d;

   assign data_s = data_i;
   assign ext    = ACC_WIDTH'(data_s);
   assign acc_o  = acc_q;

`ifdef ACC_SAT_EN
   logic ovf_q;
   logic ovf_d;
   logic sat_ovf;

   // Next-state: clear wins, otherwise clamp-add and accumulate the sticky flag
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      sat_ovf = 1'b0;
      if (clr_i) begin
         acc_d = '0;
         ovf_d = 1'b0;
      end else if (en_i) begin
         acc_d = ACC_WIDTH'(sat_add(wide_t'(acc_q), wide_t'(ext), ACC_WIDTH, sat_ovf));
         ovf_d = ovf_q | sat_ovf;
      end
   end

   // Sticky overflow register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ovf_q <= 1'b0;
      else        ovf_q <= ovf_d;
   end

   assign ovf_o = ovf_q;
`else
   // Next-state: clear wins, otherwise a plain two's-complement wrapping add
   always_comb begin
      acc_d = acc_q;
      if (clr_i)     acc_d = '0;
      else if (en_i) acc_d = acc_q + ext;
   end

   assign ovf_o = 1'b0;
`endif

   // Lane sum register
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignment so all flops update together.
      if (!rst_n) acc_q <= '0;
      else        acc_q <= acc_d;
   end

endmodule

// File: rtl/acc_multi_lane.sv
// Multi-lane signed accumulator: sums LANES-wide beats under valid/ready, closes on
// in_last and holds per-lane sums plus beat count until the result is taken.
// Optional feature macro: ACC_SAT_EN (saturating lanes, sticky out_ovf flags).
module acc_multi_lane
   import acc_pkg::*;
#(
   parameter int WIDTH     = ACC_DEF_WIDTH,
   parameter int ACC_WIDTH = ACC_DEF_ACC_WIDTH,
   parameter int LANES     = ACC_DEF_LANES,
   parameter int CNT_WIDTH = ACC_DEF_CNT_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [LANES*WIDTH-1:0]     in_data,
   input  logic                       in_last,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [LANES*ACC_WIDTH-1:0] out_data,
   output logic [CNT_WIDTH-1:0]       out_count,
   output logic [LANES-1:0]           out_ovf
);

   acc_state_e           state_q;
   acc_state_e           state_d;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] cnt_d;
   logic                 acc_en;
   logic                 acc_clr;

   // A beat presented alongside clear is discarded rather than summed
   assign in_ready  = (state_q == ACCUM);
   assign out_valid = (state_q == HOLD);
   assign acc_en    = in_valid & in_ready & ~clear;
   assign out_count = cnt_q;

   // FSM next-state and the accumulator clear strobe (clear or result handoff)
   always_comb begin
      state_d = state_q;
      acc_clr = 1'b0;
      if (clear) begin
         state_d = ACCUM;
         acc_clr = 1'b1;
      end else begin
         case (state_q)
            ACCUM: if (acc_en && in_last) state_d = HOLD;
            HOLD: begin
               if (out_ready) begin
                  state_d = ACCUM;
                  acc_clr = 1'b1;
               end
            end
            default: state_d = ACCUM;
         endcase
      end
   end

   // Beat counter next-state, saturating at all-ones
   always_comb begin
      cnt_d = cnt_q;
      if (acc_clr)                                   cnt_d = '0;
      else if (acc_en && (cnt_q != {CNT_WIDTH{1'b1}})) cnt_d = cnt_q + CNT_WIDTH'(1);
   end

   // State and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACCUM;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      acc_lane #(
         .WIDTH     (WIDTH),
         .ACC_WIDTH (ACC_WIDTH)
      ) u_lane (
         .clk    (clk),
         .rst_n  (rst_n),
         .clr_i  (acc_clr),
         .en_i   (acc_en),
         .data_i (in_data[i*WIDTH +: WIDTH]),
         .acc_o  (out_data[i*ACC_WIDTH +: ACC_WIDTH]),
         .ovf_o  (out_ovf[i])
      );
   end

endmodule

// File: tb/tb_acc_multi_lane.sv
// Directed bench for acc_multi_lane: a default-width instance and a narrow instance
// (WIDTH=ACC_WIDTH=8, CNT_WIDTH=2) for wrap/saturate and counter saturation.
module tb_acc_multi_lane;

   logic clk;
   logic rst_n;

   // Default instance: WIDTH=32, ACC_WIDTH=40, LANES=4, CNT_WIDTH=16
   logic         clear, in_valid, in_last, out_ready;
   logic [127:0] in_data;
   logic         in_ready, out_valid;
   logic [159:0] out_data;
   logic [15:0]  out_count;
   logic [3:0]   out_ovf;

   // Narrow instance: WIDTH=8, ACC_WIDTH=8, LANES=4, CNT_WIDTH=2
   logic         clear_n, in_valid_n, in_last_n, out_ready_n;
   logic [31:0]  in_data_n;
   logic         in_ready_n, out_valid_n;
   logic [31:0]  out_data_n;
   logic [1:0]   out_count_n;
   logic [3:0]   out_ovf_n;

   int n_checks = 0;
   int n_pass   = 0;

   acc_multi_lane dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_count (out_count),
      .out_ovf   (out_ovf)
   );

   acc_multi_lane #(
      .WIDTH     (8),
      .ACC_WIDTH (8),
      .LANES     (4),
      .CNT_WIDTH (2)
   ) dut_n (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear_n),
      .in_valid  (in_valid_n),
      .in_ready  (in_ready_n),
      .in_data   (in_data_n),
      .in_last   (in_last_n),
      .out_valid (out_valid_n),
      .out_ready (out_ready_n),
      .out_data  (out_data_n),
      .out_count (out_count_n),
      .out_ovf   (out_ovf_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [127:0] vec32(input int a0, input int a1, input int a2, input int a3);
      return {a3, a2, a1, a0};
   endfunction

   function automatic logic [159:0] vec40(input longint a0, input longint a1,
                                          input longint a2, input longint a3);
      return {a3[39:0], a2[39:0], a1[39:0], a0[39:0]};
   endfunction

   // Advance to 1 time unit past the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [127:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_beat_n(input logic [31:0] d, input logic last);
      in_valid_n = 1'b1;
      in_data_n  = d;
      in_last_n  = last;
      tick();
      in_valid_n = 1'b0;
      in_last_n  = 1'b0;
   endtask

   task automatic handoff();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic handoff_n();
      out_ready_n = 1'b1;
      tick();
      out_ready_n = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_data = '0;
      clear_n = 1'b0; in_valid_n = 1'b0; in_last_n = 1'b0; out_ready_n = 1'b0; in_data_n = '0;
      #12;
      n_checks++;
      if ({in_ready, out_valid, out_count, out_ovf} !== {1'b1, 1'b0, 16'd0, 4'd0})
         $display("FAIL reset_ctrl: got rdy=%b vld=%b cnt=%0d ovf=%b want 1 0 0 0",
                  in_ready, out_valid, out_count, out_ovf);
      else n_pass++;
      n_checks++;
      if (out_data !== 160'd0) $display("FAIL reset_data: got %h want 0", out_data);
      else n_pass++;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic_sum();
      send_beat(vec32(1, 2, 3, 4), 1'b0);
      send_beat(vec32(10, 20, 30, 40), 1'b0);
      send_beat(vec32(-5, -5, -5, -5), 1'b1);
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0)
         $display("FAIL basic_valid: got vld=%b rdy=%b want 1 0", out_valid, in_ready);
      else n_pass++;
      n_checks++;
      if (out_data !== vec40(6, 17, 28, 39))
         $display("FAIL basic_data: got %h want %h", out_data, vec40(6, 17, 28, 39));
      else n_pass++;
      n_checks++;
      if (out_count !== 16'd3) $display("FAIL basic_count: got %0d want 3", out_count);
      else n_pass++;
   endtask

   // Entered with the basic-sum result still held
   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = vec32(1000, 1000, 1000, 1000);
      for (int i = 0; i < 10; i++) begin
         tick();
         n_checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== vec40(6, 17, 28, 39)
             || out_count !== 16'd3)
            $display("FAIL hold_stable[%0d]: got vld=%b rdy=%b cnt=%0d data=%h", i,
                     out_valid, in_ready, out_count, out_data);
         else n_pass++;
      end
      out_ready = 1'b1;
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL handoff_ctrl: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
      else n_pass++;
      n_checks++;
      if (out_data !== 160'd0 || out_count !== 16'd0)
         $display("FAIL handoff_clr: got data=%h cnt=%0d want 0 0", out_data, out_count);
      else n_pass++;
   endtask

   task automatic test_clear();
      send_beat(vec32(7, 7, 7, 7), 1'b0);
      send_beat(vec32(7, 7, 7, 7), 1'b0);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = vec32(100, 100, 100, 100);
      tick();
      clear    = 1'b0;
      in_valid = 1'b0;
      n_checks++;
      if (out_data !== 160'd0 || out_count !== 16'd0 || out_valid !== 1'b0)
         $display("FAIL clear_mid: got data=%h cnt=%0d vld=%b want 0 0 0",
                  out_data, out_count, out_valid);
      else n_pass++;
      send_beat(vec32(1, 1, 1, 1), 1'b1);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== vec40(1, 1, 1, 1) || out_count !== 16'd1)
         $display("FAIL clear_after: got vld=%b data=%h cnt=%0d want 1 lanes=1 1",
                  out_valid, out_data, out_count);
      else n_pass++;
      // Clear while holding drops the pending result
      clear = 1'b1;
      tick();
      clear = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== 16'd0)
         $display("FAIL clear_hold: got vld=%b rdy=%b cnt=%0d want 0 1 0",
                  out_valid, in_ready, out_count);
      else n_pass++;
   endtask

   task automatic test_last_without_valid();
      in_last  = 1'b1;
      in_valid = 1'b0;
      tick();
      tick();
      in_last = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || out_count !== 16'd0)
         $display("FAIL last_no_valid: got vld=%b cnt=%0d want 0 0", out_valid, out_count);
      else n_pass++;
   endtask

   task automatic test_reset_in_hold();
      send_beat(vec32(3, 3, 3, 3), 1'b1);
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1) $display("FAIL rst_hold_pre: got vld=%b want 1", out_valid);
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 160'd0 || out_count !== 16'd0)
         $display("FAIL rst_hold_async: got vld=%b rdy=%b data=%h cnt=%0d want 0 1 0 0",
                  out_valid, in_ready, out_data, out_count);
      else n_pass++;
      #1 rst_n = 1'b1;
      send_beat(vec32(5, 5, 5, 5), 1'b1);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== vec40(5, 5, 5, 5) || out_count !== 16'd1)
         $display("FAIL rst_fresh: got vld=%b data=%h cnt=%0d want 1 lanes=5 1",
                  out_valid, out_data, out_count);
      else n_pass++;
      handoff();
   endtask

   task automatic test_wrap_sat();
      logic [31:0] exp_data;
      logic [3:0]  exp_ovf;
`ifdef ACC_SAT_EN
      exp_data = 32'h0000_007F;
      exp_ovf  = 4'b0001;
`else
      exp_data = 32'h0000_00C8;
      exp_ovf  = 4'b0000;
`endif
      send_beat_n(32'h0000_0064, 1'b0);
      send_beat_n(32'h0000_0064, 1'b1);
      n_checks++;
      if (out_valid_n !== 1'b1 || out_data_n !== exp_data || out_count_n !== 2'd2)
         $display("FAIL wrap_sat_data: got vld=%b data=%h cnt=%0d want 1 %h 2",
                  out_valid_n, out_data_n, out_count_n, exp_data);
      else n_pass++;
      n_checks++;
      if (out_ovf_n !== exp_ovf)
         $display("FAIL wrap_sat_ovf: got %b want %b", out_ovf_n, exp_ovf);
      else n_pass++;
      handoff_n();
      n_checks++;
      if (out_ovf_n !== 4'b0000 || out_data_n !== 32'd0)
         $display("FAIL wrap_sat_clr: got ovf=%b data=%h want 0 0", out_ovf_n, out_data_n);
      else n_pass++;
   endtask

   task automatic test_cnt_sat();
      for (int i = 0; i < 5; i++) send_beat_n(32'h0101_0101, (i == 4));
      n_checks++;
      if (out_valid_n !== 1'b1 || out_data_n !== 32'h0505_0505)
         $display("FAIL cnt_sat_data: got vld=%b data=%h want 1 05050505", out_valid_n, out_data_n);
      else n_pass++;
      n_checks++;
      if (out_count_n !== 2'd3) $display("FAIL cnt_sat_count: got %0d want 3", out_count_n);
      else n_pass++;
      handoff_n();
   endtask

   initial begin
      test_reset();
      test_basic_sum();
      test_backpressure();
      test_clear();
      test_last_without_valid();
      test_reset_in_hold();
      test_wrap_sat();
      test_cnt_sat();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
